// File: rtl/hour_set_entry_if.sv
// Keypad-side hour entry bus: digit strobes and mode inputs in, committed hour and status out.
// master = digit-entry front end, slave = hour_set_entry.
interface hour_set_entry_if;
  logic       KEY_VALID;
  logic [3:0] KEY_DIGIT;
  logic       CANCEL;
  logic       MODE24;
  logic       PM;
  logic [4:0] HOUR;
  logic       LOAD;
  logic       ERR;
  logic       BUSY;
  logic [1:0] DH;
  logic [3:0] DL;

  modport master (
    output KEY_VALID, KEY_DIGIT, CANCEL, MODE24, PM,
    input  HOUR, LOAD, ERR, BUSY, DH, DL
  );

  modport slave (
    input  KEY_VALID, KEY_DIGIT, CANCEL, MODE24, PM,
    output HOUR, LOAD, ERR, BUSY, DH, DL
  );
endinterface

// File: rtl/hour_set_entry.sv
// Two-digit BCD hour entry -> binary hour 0-23; LOAD one cycle after the units strobe, no backpressure.
// HOURSET_ECHO_EN builds the DH/DL digit echo registers; without it DH/DL read 0.
module hour_set_entry #(
  parameter int unsigned TO_CYCLES = 100000000,
  parameter int unsigned TO_W      = 27
) (
  input logic             CLK,
  input logic             RST,
  hour_set_entry_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] TENS = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  logic [1:0]      state;
  logic [1:0]      tens;
  logic [TO_W-1:0] timer;
  logic [4:0]      hour;
  logic            load;
  logic            err;

  logic            digit_ok;
  logic            tens_ok;
  logic [4:0]      sum;
  logic            units_ok;
  logic [4:0]      hour_new;
  logic            timeout;
  logic            idle_key;
  logic            tens_key;
  logic            tens_take;
  logic            units_take;

  // BCD->binary as tens*8 + tens*2 + units; only trusted once digit_ok holds
  assign digit_ok = bus.KEY_DIGIT <= 4'd9;
  assign tens_ok  = bus.MODE24 ? (bus.KEY_DIGIT <= 4'd2) : (bus.KEY_DIGIT <= 4'd1);
  assign sum      = 5'({tens, 3'b000}) + 5'({tens, 1'b0}) + 5'(bus.KEY_DIGIT);
  assign units_ok = digit_ok && (bus.MODE24 ? (sum <= 5'd23) : (sum <= 5'd11));
  assign hour_new = (!bus.MODE24 && bus.PM) ? (sum + 5'd12) : sum;
  assign timeout  = timer == TO_LAST;

  assign idle_key   = !bus.CANCEL && bus.KEY_VALID && (state == IDLE);
  assign tens_key   = !bus.CANCEL && bus.KEY_VALID && (state == TENS);
  assign tens_take  = idle_key && tens_ok;
  assign units_take = tens_key && units_ok;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      tens  <= 2'd0;
      timer <= '0;
      hour  <= 5'd0;
      load  <= 1'b0;
      err   <= 1'b0;
    end else begin
      load <= 1'b0;
      err  <= 1'b0;
      if (bus.CANCEL) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.KEY_VALID) begin
              if (tens_ok) begin
                tens  <= bus.KEY_DIGIT[1:0];
                timer <= '0;
                state <= TENS;
              end else begin
                err <= 1'b1;
              end
            end
          end
          TENS: begin
            // a strobe on the timeout cycle takes priority over the timeout
            if (bus.KEY_VALID) begin
              if (units_ok) begin
                hour  <= hour_new;
                load  <= 1'b1;
                state <= DONE;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end else if (timeout) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              timer <= timer + TO_W'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.HOUR = hour;
  assign bus.LOAD = load;
  assign bus.ERR  = err;
  assign bus.BUSY = state == TENS;

`ifdef HOURSET_ECHO_EN
  logic [3:0] dl;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             dl <= 4'd0;
    else if (tens_take)  dl <= 4'd0;
    else if (units_take) dl <= bus.KEY_DIGIT;
  end

  assign bus.DH = tens;
  assign bus.DL = dl;
`else
  logic unused_echo;
  assign unused_echo = tens_take ^ units_take;
  assign bus.DH = 2'd0;
  assign bus.DL = 4'd0;
`endif

endmodule

// File: tb/tb_hour_set_entry.sv
// Bench for hour_set_entry: directed scenarios plus random digit traffic against a behavioural model.
module tb_hour_set_entry;
  localparam int TO = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  hour_set_entry_if bus ();

  hour_set_entry #(.TO_CYCLES(TO), .TO_W(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model: entry is "waiting for units" or not; hour = tens*10 + units (+12 if PM)
  int m_hour, m_tens, m_age, m_eh, m_el;
  bit m_wait, m_done, m_load, m_err;

  task automatic model_reset();
    m_hour = 0; m_tens = 0; m_age = 0; m_eh = 0; m_el = 0;
    m_wait = 0; m_done = 0; m_load = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit kv, input int kd, input bit c, input bit m24, input bit pm);
    int v;
    m_load = 0;
    m_err  = 0;
    if (c) begin
      m_wait = 0;
      m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_wait) begin
      if (kv) begin
        if (kd <= (m24 ? 2 : 1)) begin
          m_wait = 1; m_tens = kd; m_age = 0; m_eh = kd; m_el = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (kv) begin
      v = m_tens * 10 + kd;
      if (kd <= 9 && v <= (m24 ? 23 : 11)) begin
        m_hour = (!m24 && pm) ? v + 12 : v;
        m_el = kd; m_load = 1; m_done = 1;
      end else begin
        m_err = 1;
      end
      m_wait = 0;
    end else begin
      m_age++;
      if (m_age == TO) begin
        m_err = 1;
        m_wait = 0;
      end
    end
  endtask

  function automatic logic [13:0] expv();
    logic [1:0] dh;
    logic [3:0] dl;
`ifdef HOURSET_ECHO_EN
    dh = 2'(m_eh);
    dl = 4'(m_el);
`else
    dh = 2'd0;
    dl = 4'd0;
`endif
    return {5'(m_hour), m_load, m_err, m_wait, dh, dl};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.HOUR, bus.LOAD, bus.ERR, bus.BUSY, bus.DH, bus.DL};
  endfunction

  task automatic step(input bit kv, input logic [3:0] kd, input bit c, input bit m24, input bit pm);
    bus.KEY_VALID = kv;
    bus.KEY_DIGIT = kd;
    bus.CANCEL    = c;
    bus.MODE24    = m24;
    bus.PM        = pm;
    @(posedge CLK);
    model_edge(kv, int'(kd), c, m24, pm);
    #1;
  endtask

  task automatic test_reset();
    bus.KEY_VALID = 0; bus.KEY_DIGIT = 0; bus.CANCEL = 0; bus.MODE24 = 1; bus.PM = 0;
    RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (obs() !== 14'h0) begin
      n_bad++; $display("FAIL reset: got %h want %h", obs(), 14'h0);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== expv()) begin
      n_bad++; $display("FAIL reset_release: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_24h();
    step(1, 4'd2, 0, 1, 0);
    n_cmp++;
    if (obs() !== expv() || bus.BUSY !== 1'b1) begin
      n_bad++; $display("FAIL h24_tens: got %h want %h", obs(), expv());
    end
    step(1, 4'd3, 0, 1, 0);
    n_cmp++;
    if (bus.LOAD !== 1'b1 || bus.HOUR !== 5'd23 || bus.ERR !== 1'b0) begin
      n_bad++; $display("FAIL h24_load: got load=%b hour=%0d err=%b want 1/23/0", bus.LOAD, bus.HOUR, bus.ERR);
    end
    step(0, 4'd0, 0, 1, 0);
    n_cmp++;
    if (obs() !== expv() || bus.LOAD !== 1'b0) begin
      n_bad++; $display("FAIL h24_after: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_12h();
    step(1, 4'd1, 0, 0, 1);
    step(1, 4'd1, 0, 0, 1);
    n_cmp++;
    if (bus.HOUR !== 5'd23 || bus.LOAD !== 1'b1) begin
      n_bad++; $display("FAIL h12_pm: got hour=%0d load=%b want 23/1", bus.HOUR, bus.LOAD);
    end
    step(0, 4'd0, 0, 0, 0);
    step(1, 4'd1, 0, 0, 0);
    step(1, 4'd1, 0, 0, 0);
    n_cmp++;
    if (bus.HOUR !== 5'd11 || obs() !== expv()) begin
      n_bad++; $display("FAIL h12_am: got %h want %h", obs(), expv());
    end
    step(0, 4'd0, 0, 0, 0);
    step(1, 4'd1, 0, 0, 1);
    step(1, 4'd2, 0, 0, 1);
    n_cmp++;
    if (bus.ERR !== 1'b1 || bus.HOUR !== 5'd11 || bus.LOAD !== 1'b0) begin
      n_bad++; $display("FAIL h12_bad: got err=%b hour=%0d load=%b want 1/11/0", bus.ERR, bus.HOUR, bus.LOAD);
    end
  endtask

  task automatic test_invalid();
    step(1, 4'd3, 0, 1, 0);
    n_cmp++;
    if (bus.ERR !== 1'b1 || bus.BUSY !== 1'b0) begin
      n_bad++; $display("FAIL bad_tens: got err=%b busy=%b want 1/0", bus.ERR, bus.BUSY);
    end
    step(1, 4'd12, 0, 1, 0);
    n_cmp++;
    if (obs() !== expv() || bus.ERR !== 1'b1) begin
      n_bad++; $display("FAIL tens_gt9: got %h want %h", obs(), expv());
    end
    step(1, 4'd2, 0, 1, 0);
    step(1, 4'd4, 0, 1, 0);
    n_cmp++;
    if (bus.ERR !== 1'b1 || bus.BUSY !== 1'b0 || bus.HOUR !== 5'(m_hour) || obs() !== expv()) begin
      n_bad++; $display("FAIL bad_units: got %h want %h", obs(), expv());
    end
    // tens accepted in 24h mode, units checked against the 12h limit
    step(1, 4'd2, 0, 1, 0);
    step(1, 4'd1, 0, 0, 0);
    n_cmp++;
    if (bus.ERR !== 1'b1 || obs() !== expv()) begin
      n_bad++; $display("FAIL mode_switch: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_timeout();
    int err_at;
    err_at = -1;
    step(1, 4'd1, 0, 0, 0);
    for (int i = 1; i <= TO + 1; i++) begin
      step(0, 4'd0, 0, 0, 0);
      if (bus.ERR === 1'b1 && err_at < 0) err_at = i;
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL timeout_cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
    n_cmp++;
    if (err_at !== TO) begin
      n_bad++; $display("FAIL timeout_at: got %0d want %0d", err_at, TO);
    end
    step(1, 4'd2, 0, 1, 0);
    n_cmp++;
    if (bus.BUSY !== 1'b1 || bus.ERR !== 1'b0 || bus.LOAD !== 1'b0) begin
      n_bad++; $display("FAIL timeout_retens: got busy=%b err=%b load=%b want 1/0/0", bus.BUSY, bus.ERR, bus.LOAD);
    end
    step(0, 4'd0, 1, 1, 0);
    // a units strobe on the timeout cycle wins
    step(1, 4'd1, 0, 0, 0);
    repeat (TO - 1) step(0, 4'd0, 0, 0, 0);
    step(1, 4'd0, 0, 0, 0);
    n_cmp++;
    if (bus.LOAD !== 1'b1 || bus.ERR !== 1'b0 || bus.HOUR !== 5'd10) begin
      n_bad++; $display("FAIL timeout_key: got load=%b err=%b hour=%0d want 1/0/10", bus.LOAD, bus.ERR, bus.HOUR);
    end
    step(0, 4'd0, 0, 0, 0);
  endtask

  task automatic test_cancel();
    logic [4:0] h_before;
    step(1, 4'd1, 0, 1, 0);
    h_before = 5'(m_hour);
    step(1, 4'd5, 1, 1, 0);
    n_cmp++;
    if (bus.LOAD !== 1'b0 || bus.ERR !== 1'b0 || bus.BUSY !== 1'b0 || bus.HOUR !== h_before) begin
      n_bad++; $display("FAIL cancel_units: got %h want %h", obs(), expv());
    end
    step(1, 4'd9, 1, 1, 0);
    n_cmp++;
    if (bus.ERR !== 1'b0 || obs() !== expv()) begin
      n_bad++; $display("FAIL cancel_idle: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_rst_done();
    step(1, 4'd1, 0, 1, 0);
    step(1, 4'd5, 0, 1, 0);
    n_cmp++;
    if (bus.LOAD !== 1'b1 || bus.HOUR !== 5'd15) begin
      n_bad++; $display("FAIL rst_pre: got load=%b hour=%0d want 1/15", bus.LOAD, bus.HOUR);
    end
    #1 RST = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 14'h0) begin
      n_bad++; $display("FAIL rst_async: got %h want %h", obs(), 14'h0);
    end
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic [3:0] t, u;
    for (int k = 0; k < 6; k++) begin
      t = 4'($urandom_range(0, 2));
      u = (t == 4'd2) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 9));
      step(1, t, 0, 1, 0);
      step(1, u, 0, 1, 0);
      n_cmp++;
      if (bus.LOAD !== 1'b1 || bus.HOUR !== 5'(t * 10 + u) || obs() !== expv()) begin
        n_bad++; $display("FAIL b2b_load%0d: got %h want %h", k, obs(), expv());
      end
      step(1, 4'd1, 0, 1, 0);
      n_cmp++;
      if (bus.BUSY !== 1'b0 || bus.LOAD !== 1'b0 || obs() !== expv()) begin
        n_bad++; $display("FAIL b2b_done%0d: got %h want %h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    bit kv, c, m24, pm;
    logic [3:0] kd;
    for (int i = 0; i < 3000; i++) begin
      kv  = $urandom_range(0, 2) == 0;
      kd  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      c   = $urandom_range(0, 23) == 0;
      m24 = $urandom_range(0, 2) != 0;
      pm  = 1'($urandom_range(0, 1));
      step(kv, kd, c, m24, pm);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL random_cyc%0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_24h();
    test_12h();
    test_invalid();
    test_timeout();
    test_cancel();
    test_rst_done();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
